lc3_mem_responder: RTL and testbench

Instruction- and data-memory responder that sits directly outside the LC3 core. It services the fetch stage's instruction requests and the memory-access stage's data reads and writes. Each port has its own programmable wait-state latency. The block drives the `complete_instr` and `complete_data` handshakes the core stalls on, and has a side-band preload port so a bench can initialise both memories.

---
 rtl/lc3_mem_responder.sv | 142 ++++++++++++++
 tb/tb_lc3_mem_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_responder.sv
// rtl/lc3_mem_responder.sv - LC3 instruction/data memory responder with per-port wait states
// Two independent IDLE/WAIT/DONE ports share one preload path; completions are one-cycle pulses.
module lc3_mem_responder #(
  parameter int AW       = 8,
  parameter int IMEM_LAT = 0,
  parameter int DMEM_LAT = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [15:0]   pc,
  input  logic          instrmem_rd,
  output logic [15:0]   Instr_dout,
  output logic          complete_instr,
  input  logic          data_req,
  input  logic          Data_rd,
  input  logic [15:0]   Data_addr,
  input  logic [15:0]   Data_din,
  output logic [15:0]   Data_dout,
  output logic          complete_data,
  input  logic          load_en,
  input  logic          load_sel,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  output logic          imem_busy,
  output logic          dmem_busy
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] ILAT = 4'(IMEM_LAT);
  localparam logic [3:0] DLAT = 4'(DMEM_LAT);

  logic [15:0] imem [2**AW];
  logic [15:0] dmem [2**AW];

  state_t      iState, iNext, dState, dNext;
  logic [3:0]  iCnt, iCntNext, dCnt, dCntNext;
  logic        iAccept, dAccept, dIsRead, dReadNow;
  logic [15:0] iCap, dCap;
  logic [AW-1:0] iIdx, dIdx;
  logic        unusedAddrBits;

  // Only the low AW address bits select a word; the rest alias.
  assign iIdx = pc[AW-1:0];
  assign dIdx = Data_addr[AW-1:0];
  assign unusedAddrBits = ^{pc[15:AW], Data_addr[15:AW]};

  always_comb begin
    iNext    = iState;
    iCntNext = iCnt;
    iAccept  = 1'b0;
    case (iState)
      IDLE: if (instrmem_rd) begin
        iAccept = 1'b1;
        if (ILAT == 4'd0) iNext = DONE;
        else begin
          iNext    = WAIT;
          iCntNext = ILAT;
        end
      end
      WAIT: begin
        iCntNext = iCnt - 4'd1;
        if (iCnt == 4'd1) iNext = DONE;
      end
      DONE:    iNext = IDLE;
      default: iNext = IDLE;
    endcase
  end

  always_comb begin
    dNext    = dState;
    dCntNext = dCnt;
    dAccept  = 1'b0;
    case (dState)
      IDLE: if (data_req) begin
        dAccept = 1'b1;
        if (DLAT == 4'd0) dNext = DONE;
        else begin
          dNext    = WAIT;
          dCntNext = DLAT;
        end
      end
      WAIT: begin
        dCntNext = dCnt - 4'd1;
        if (dCnt == 4'd1) dNext = DONE;
      end
      DONE:    dNext = IDLE;
      default: dNext = IDLE;
    endcase
  end

  // With zero latency the DONE entry coincides with acceptance, so dout bypasses the capture register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      iState     <= IDLE;
      iCnt       <= 4'd0;
      iCap       <= 16'h0000;
      Instr_dout <= 16'h0000;
    end else begin
      iState <= iNext;
      iCnt   <= iCntNext;
      if (iAccept) iCap <= imem[iIdx];
      if (iNext == DONE) Instr_dout <= (iState == IDLE) ? imem[iIdx] : iCap;
    end
  end

  assign dReadNow = (dState == IDLE) ? Data_rd : dIsRead;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dState    <= IDLE;
      dCnt      <= 4'd0;
      dCap      <= 16'h0000;
      dIsRead   <= 1'b0;
      Data_dout <= 16'h0000;
    end else begin
      dState <= dNext;
      dCnt   <= dCntNext;
      if (dAccept) begin
        dCap    <= dmem[dIdx];
        dIsRead <= Data_rd;
      end
      if (dNext == DONE && dReadNow) Data_dout <= (dState == IDLE) ? dmem[dIdx] : dCap;
    end
  end

  // Preload is applied last so it wins over a same-word core write on the same edge.
  always_ff @(posedge clock) begin
    if (dAccept && !Data_rd) dmem[dIdx] <= Data_din;
    if (load_en && load_sel) dmem[load_addr] <= load_data;
  end

  always_ff @(posedge clock) begin
    if (load_en && !load_sel) imem[load_addr] <= load_data;
  end

  assign complete_instr = (iState == DONE);
  assign complete_data  = (dState == DONE);
  assign imem_busy      = (iState != IDLE);
  assign dmem_busy      = (dState != IDLE);

endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb/tb_lc3_mem_responder.sv - bench for lc3_mem_responder, two latency configurations
// Model tracks each access by its acceptance edge index rather than by state.
module tb_lc3_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pc, Data_addr, Data_din, load_data;
  logic        instrmem_rd, data_req, Data_rd, load_en, load_sel;
  logic [7:0]  load_addr;

  logic [15:0] iDo [2];
  logic [15:0] dDo [2];
  logic        cI [2];
  logic        cD [2];
  logic        bI [2];
  logic        bD [2];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  lc3_mem_responder #(.AW(8), .IMEM_LAT(0), .DMEM_LAT(2)) dut0 (
    .clock(clock), .reset(reset), .pc(pc), .instrmem_rd(instrmem_rd),
    .Instr_dout(iDo[0]), .complete_instr(cI[0]), .data_req(data_req),
    .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .Data_dout(dDo[0]), .complete_data(cD[0]), .load_en(load_en),
    .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
    .imem_busy(bI[0]), .dmem_busy(bD[0])
  );

  lc3_mem_responder #(.AW(8), .IMEM_LAT(1), .DMEM_LAT(1)) dut1 (
    .clock(clock), .reset(reset), .pc(pc), .instrmem_rd(instrmem_rd),
    .Instr_dout(iDo[1]), .complete_instr(cI[1]), .data_req(data_req),
    .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .Data_dout(dDo[1]), .complete_data(cD[1]), .load_en(load_en),
    .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
    .imem_busy(bI[1]), .dmem_busy(bD[1])
  );

  // Model: index [instance][port], port 0 = instruction, 1 = data.
  int          edgeN = 0;
  int          accA [2][2];
  int          accD [2][2];
  int          nextFree [2][2];
  bit          act [2][2];
  bit          isRd [2][2];
  logic [15:0] cap [2][2];
  logic [15:0] expDo [2][2];
  logic [15:0] mMem [2][2][256];

  function automatic int lat(input int k, input int p);
    if (k == 0) return (p == 0) ? 0 : 2;
    return 1;
  endfunction

  function automatic bit expComplete(input int k, input int p);
    return act[k][p] && edgeN == accD[k][p];
  endfunction

  function automatic bit expBusy(input int k, input int p);
    return act[k][p] && edgeN >= accA[k][p] && edgeN <= accD[k][p];
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        act[k][p]      = 1'b0;
        expDo[k][p]    = 16'h0000;
        nextFree[k][p] = 0;
      end
  endtask

  always @(posedge clock) begin : model
    logic req;
    int   idx;
    edgeN++;
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < 2; p++) begin
          req = (p == 0) ? instrmem_rd : data_req;
          idx = (p == 0) ? int'(pc[7:0]) : int'(Data_addr[7:0]);
          if (req && edgeN >= nextFree[k][p]) begin
            act[k][p]      = 1'b1;
            accA[k][p]     = edgeN;
            accD[k][p]     = edgeN + lat(k, p);
            nextFree[k][p] = accD[k][p] + 2;
            isRd[k][p]     = (p == 0) || Data_rd;
            cap[k][p]      = mMem[k][p][idx];
            if (!isRd[k][p]) mMem[k][1][idx] = Data_din;
          end
          if (act[k][p] && edgeN == accD[k][p] && isRd[k][p]) expDo[k][p] = cap[k][p];
        end
        if (load_en) mMem[k][load_sel][load_addr] = load_data;
      end
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d complete_instr", k), {15'd0, cI[k]}, {15'd0, expComplete(k, 0)});
      chk($sformatf("dut%0d complete_data", k), {15'd0, cD[k]}, {15'd0, expComplete(k, 1)});
      chk($sformatf("dut%0d imem_busy", k), {15'd0, bI[k]}, {15'd0, expBusy(k, 0)});
      chk($sformatf("dut%0d dmem_busy", k), {15'd0, bD[k]}, {15'd0, expBusy(k, 1)});
      chk($sformatf("dut%0d Instr_dout", k), iDo[k], expDo[k][0]);
      chk($sformatf("dut%0d Data_dout", k), dDo[k], expDo[k][1]);
    end
  end

  task automatic doReset();
    @(posedge clock);
    #2;
    reset = 1'b0;
    instrmem_rd = 1'b0;
    data_req = 1'b0;
    load_en = 1'b0;
    modelReset();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("async reset dut%0d complete_data", k), {15'd0, cD[k]}, 16'd0);
      chk($sformatf("async reset dut%0d dmem_busy", k), {15'd0, bD[k]}, 16'd0);
    end
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((bI[0] | bI[1] | bD[0] | bD[1]) && n < 30) begin
      @(negedge clock);
      n++;
    end
    chk("wait idle", {15'd0, bI[0] | bI[1] | bD[0] | bD[1]}, 16'd0);
  endtask

  task automatic dataAcc(input bit rd, input logic [15:0] addr, input logic [15:0] din,
                         output int cyc, output logic [15:0] val);
    waitIdle();
    @(negedge clock);
    data_req = 1'b1;
    Data_rd = rd;
    Data_addr = addr;
    Data_din = din;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!cD[0] && cyc < 40);
    chk("data access completed", {15'd0, cD[0]}, 16'd1);
    val = dDo[0];
    data_req = 1'b0;
  endtask

  initial begin
    int cyc, pulses, firstAt;
    logic [15:0] v;
    reset = 1'b0;
    pc = 16'h0; instrmem_rd = 1'b0; data_req = 1'b0; Data_rd = 1'b0;
    Data_addr = 16'h0; Data_din = 16'h0;
    load_en = 1'b0; load_sel = 1'b0; load_addr = 8'h0; load_data = 16'h0;
    modelReset();
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;

    @(negedge clock);
    chk("reset Instr_dout", iDo[0], 16'h0000);
    chk("reset Data_dout", dDo[0], 16'h0000);
    chk("reset complete_instr", {15'd0, cI[0]}, 16'd0);
    chk("reset imem_busy", {15'd0, bI[0]}, 16'd0);

    for (int i = 0; i < 256; i++)
      for (int s = 0; s < 2; s++) begin
        @(negedge clock);
        load_en = 1'b1; load_sel = s[0]; load_addr = i[7:0]; load_data = 16'($urandom);
      end
    @(negedge clock);
    load_sel = 1'b0; load_addr = 8'h05; load_data = 16'h1234;
    @(negedge clock);
    load_en = 1'b0;

    waitIdle();
    @(negedge clock);
    pc = 16'h3005;
    instrmem_rd = 1'b1;
    pulses = 0;
    firstAt = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clock);
      if (cI[0]) begin
        pulses++;
        if (firstAt == 0) firstAt = n;
        chk("imem lat0 data", iDo[0], 16'h1234);
      end
    end
    instrmem_rd = 1'b0;
    chk("imem pulses in 6 cycles", 16'(pulses), 16'd3);
    chk("imem first pulse latency", 16'(firstAt), 16'd1);

    dataAcc(1'b0, 16'h0010, 16'hBEEF, cyc, v);
    chk("write latency", 16'(cyc), 16'd3);
    chk("Data_dout untouched by write", v, 16'h0000);
    dataAcc(1'b1, 16'h0010, 16'h0000, cyc, v);
    chk("read latency", 16'(cyc), 16'd3);
    chk("read back 0x0010", v, 16'hBEEF);
    dataAcc(1'b1, 16'h0110, 16'h0000, cyc, v);
    chk("aliased read 0x0110", v, 16'hBEEF);

    waitIdle();
    @(negedge clock);
    data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h0010;
    @(negedge clock);
    chk("busy during WAIT", {15'd0, bD[0]}, 16'd1);
    doReset();
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      if (cD[0] | cD[1]) pulses++;
    end
    chk("no completion after reset", 16'(pulses), 16'd0);

    waitIdle();
    @(negedge clock);
    data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h0020; Data_din = 16'h1111;
    load_en = 1'b1; load_sel = 1'b1; load_addr = 8'h20; load_data = 16'h2222;
    @(negedge clock);
    load_en = 1'b0;
    cyc = 1;
    while (!cD[0] && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    chk("collision write completed", {15'd0, cD[0]}, 16'd1);
    data_req = 1'b0;
    dataAcc(1'b1, 16'h0020, 16'h0000, cyc, v);
    chk("preload wins collision", v, 16'h2222);

    waitIdle();
    @(negedge clock);
    pc = 16'h0005; instrmem_rd = 1'b1;
    data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h0010;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!(cI[1] | cD[1]) && cyc < 40);
    chk("dual complete_instr", {15'd0, cI[1]}, 16'd1);
    chk("dual complete_data", {15'd0, cD[1]}, 16'd1);
    chk("dual Instr_dout", iDo[1], 16'h1234);
    chk("dual Data_dout", dDo[1], 16'hBEEF);
    chk("dual latency", 16'(cyc), 16'd2);
    instrmem_rd = 1'b0;
    data_req = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      instrmem_rd = 1'($urandom);
      pc          = 16'($urandom);
      data_req    = 1'($urandom);
      Data_rd     = 1'($urandom);
      Data_addr   = 16'($urandom) & 16'hFF0F;
      Data_din    = 16'($urandom);
      load_en     = ($urandom_range(0, 4) == 0);
      load_sel    = 1'($urandom);
      load_addr   = 8'($urandom_range(0, 15));
      load_data   = 16'($urandom);
      if (c == 1500) doReset();
    end
    @(negedge clock);
    instrmem_rd = 1'b0; data_req = 1'b0; load_en = 1'b0;
    repeat (6) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
